// File: rtl/obi_scratch_responder.sv
// OBI responder backed by a word-addressed scratch memory.
// Terminates an external DMA master port. The grant wait and the response latency
// are parameters, so the master's stall and pipelining paths both get exercised.
// Define OBI_SCRATCH_ERR_EN to add the err_o response flag for out-of-range accesses.
module obi_scratch_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'hF000_0000,
  parameter int          NUM_WORDS       = 256,
  parameter int          GNT_WAIT        = 0,
  parameter int          RVALID_LAT      = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [15:0] err_count_o
`ifdef OBI_SCRATCH_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int AW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next, cnt_inc;
  logic [2:0]  outstanding;
  logic        can_grant;
  logic        hs;
  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        unused;

  logic [31:0] mem [NUM_WORDS];

  logic        vld_p  [RVALID_LAT];
  logic [31:0] data_p [RVALID_LAT];
`ifdef OBI_SCRATCH_ERR_EN
  logic        err_p  [RVALID_LAT];
`endif

  // A response leaving this cycle frees a slot for the grant issued in the same cycle.
  assign can_grant = (outstanding < 3'(MAX_OUTSTANDING)) || rvalid_o;
  assign hs        = req_i & gnt_o;

  assign offset   = addr_i - BASE_ADDR;
  assign in_range = (addr_i >= BASE_ADDR) && (offset[31:2] < 30'(NUM_WORDS));
  assign idx      = offset[AW+1:2];
  assign unused   = ^offset[1:0];

  // Grant FSM state and wait counter
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Grant FSM next state: WAIT moves to GRANT in the cycle the count reaches GNT_WAIT,
  // so gnt_o rises on cycle GNT_WAIT+1 of a held request.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cnt_inc    = (cnt == 4'(GNT_WAIT)) ? cnt : cnt + 4'd1;
    case (state)
      IDLE: begin
        if (GNT_WAIT != 0 && req_i && can_grant) begin
          cnt_next   = 4'd1;
          state_next = (GNT_WAIT == 1) ? GRANT : WAIT;
        end
      end
      WAIT: begin
        if (!req_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == 4'(GNT_WAIT) && can_grant) state_next = GRANT;
        end
      end
      GRANT: begin
        if (hs || !req_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Grant output; held low during reset even if the master keeps requesting
  always_comb begin
    gnt_o = 1'b0;
    if (rst_n && req_i && can_grant) begin
      if (GNT_WAIT == 0 && state == IDLE) gnt_o = 1'b1;
      if (state == GRANT)                 gnt_o = 1'b1;
    end
  end

  // Response value of the access performed in the handshake cycle
  always_comb begin
    resp_data = '0;
    resp_err  = 1'b0;
    if (!in_range) begin
      resp_err = 1'b1;
      if (!we_i) resp_data = 32'hBADC_AB1E;
    end else if (!we_i) begin
      resp_data = mem[idx];
    end
  end

  // Byte-masked memory write; contents are intentionally not reset
  always_ff @(posedge clk_gen) begin
    if (hs && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Response pipeline: stage 0 loads at the handshake, last stage drives the outputs
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RVALID_LAT; i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
`ifdef OBI_SCRATCH_ERR_EN
        err_p[i]  <= 1'b0;
`endif
      end
    end else begin
      vld_p[0]  <= hs;
      data_p[0] <= hs ? resp_data : 32'd0;
`ifdef OBI_SCRATCH_ERR_EN
      err_p[0]  <= hs & resp_err;
`endif
      for (int i = 1; i < RVALID_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        data_p[i] <= data_p[i-1];
`ifdef OBI_SCRATCH_ERR_EN
        err_p[i]  <= err_p[i-1];
`endif
      end
    end
  end

  assign rvalid_o = vld_p[RVALID_LAT-1];
  assign rdata_o  = data_p[RVALID_LAT-1];
`ifdef OBI_SCRATCH_ERR_EN
  assign err_o    = err_p[RVALID_LAT-1];
`endif

  // Granted-but-unanswered transaction count
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({hs, rvalid_o})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Saturating count of out-of-range accesses
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      err_count_o <= '0;
    end else if (hs && !in_range && err_count_o != 16'hFFFF) begin
      err_count_o <= err_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_obi_scratch_responder.sv
// Bench for obi_scratch_responder: three instances (default timing, GNT_WAIT=3/RVALID_LAT=2,
// RVALID_LAT=4/MAX_OUTSTANDING=2) share clock and reset; a reference model pushes
// expected responses at each handshake and a monitor pops them on rvalid.
module tb_obi_scratch_responder;

  logic        clk_gen = 1'b0;
  logic        rst_n;
  logic        req    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic [15:0] errc   [3];
`ifdef OBI_SCRATCH_ERR_EN
  logic        err    [3];
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq [3][$];
  logic [31:0] mm  [3][256];
  logic [31:0] last_rd [3];
  int          errexp [3];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk_gen = ~clk_gen;

  obi_scratch_responder u_dut0 (
    .clk_gen(clk_gen), .rst_n(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_count_o(errc[0])
`ifdef OBI_SCRATCH_ERR_EN
    , .err_o(err[0])
`endif
  );

  obi_scratch_responder #(.GNT_WAIT(3), .RVALID_LAT(2)) u_dut1 (
    .clk_gen(clk_gen), .rst_n(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_count_o(errc[1])
`ifdef OBI_SCRATCH_ERR_EN
    , .err_o(err[1])
`endif
  );

  obi_scratch_responder #(.RVALID_LAT(4), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk_gen(clk_gen), .rst_n(rst_n), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_count_o(errc[2])
`ifdef OBI_SCRATCH_ERR_EN
    , .err_o(err[2])
`endif
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor and reference model, sampled on the falling edge
  initial begin : mon
    exp_t        e;
    logic [31:0] off;
    logic        inr;
    forever begin
      @(negedge clk_gen);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (rst_n) begin
          if (!req[k] && gnt[k]) chk_val("gnt_without_req", 32'(gnt[k]), 32'd0);
          if (rvalid[k]) begin
            last_rd[k] = rdata[k];
            if (sbq[k].size() == 0) begin
              chk_val("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
              e = sbq[k].pop_front();
              chk_val("rdata", rdata[k], e.data);
              chk_val("latency", 32'(cyc - e.cyc), 32'(lat_of(k)));
`ifdef OBI_SCRATCH_ERR_EN
              chk_val("err_o", 32'(err[k]), 32'(e.err));
`endif
            end
          end
          if (req[k] && gnt[k]) begin
            chk_val("max_outstanding", 32'(sbq[k].size() < 2), 32'd1);
            off = addr[k] - 32'hF000_0000;
            inr = (addr[k] >= 32'hF000_0000) && (off[31:2] < 30'd256);
            e.cyc = cyc;
            e.err = !inr;
            e.data = 32'd0;
            if (!inr) begin
              if (!we[k]) e.data = 32'hBADC_AB1E;
              if (errexp[k] < 65535) errexp[k]++;
            end else if (we[k]) begin
              for (int b = 0; b < 4; b++)
                if (be[k][b]) mm[k][off[9:2]][8*b +: 8] = wdata[k][8*b +: 8];
            end else begin
              e.data = mm[k][off[9:2]];
            end
            sbq[k].push_back(e);
          end
        end
      end
    end
  end

  // One OBI request; n returns the request cycle (1-based) in which gnt was seen
  task automatic xfer(input int k, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d, output int n);
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d; n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_gen);
      if (gnt[k]) begin
        n = i;
        break;
      end
    end
    @(posedge clk_gen); #1;
    req[k] = 1'b0;
    if (n == 0) chk_val("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    repeat (8) @(posedge clk_gen);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int rv_cnt;
    logic g_seen [12];
    logic r_seen [12];
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 0; we[k] = 0; be[k] = 0; addr[k] = 0; wdata[k] = 0;
      errexp[k] = 0; last_rd[k] = 0;
    end
    repeat (3) @(posedge clk_gen);
    @(negedge clk_gen);
    chk_val("rst_gnt", 32'(gnt[0]), 32'd0);
    chk_val("rst_rvalid", 32'(rvalid[0]), 32'd0);
    chk_val("rst_rdata", rdata[0], 32'd0);
    chk_val("rst_errc0", 32'(errc[0]), 32'd0);
    chk_val("rst_errc2", 32'(errc[2]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk_gen); #1;

    // default timing: same-cycle grant, write then read back
    xfer(0, 1'b1, 4'hF, 32'hF000_0010, 32'hDEAD_BEEF, n);
    chk_val("gnt_wait0_wr", 32'(n), 32'd1);
    xfer(0, 1'b0, 4'hF, 32'hF000_0010, 32'h0, n);
    chk_val("gnt_wait0_rd", 32'(n), 32'd1);
    drain();
    chk_val("read_deadbeef", last_rd[0], 32'hDEAD_BEEF);

    // partial byte-enable write
    xfer(0, 1'b1, 4'hF, 32'hF000_0014, 32'h1122_3344, n);
    xfer(0, 1'b1, 4'b0101, 32'hF000_0014, 32'hAABB_CCDD, n);
    xfer(0, 1'b0, 4'h0, 32'hF000_0016, 32'h0, n);
    drain();
    chk_val("partial_write", last_rd[0], 32'h11BB_33DD);

    // back-to-back write then read of the same word, and the last word of memory
    xfer(0, 1'b1, 4'hF, 32'hF000_03FC, 32'h5555_AAAA, n);
    xfer(0, 1'b0, 4'hF, 32'hF000_03FC, 32'h0, n);
    drain();
    chk_val("raw_last_word", last_rd[0], 32'h5555_AAAA);

    // out of range: just past the end and just below the base
    xfer(0, 1'b0, 4'hF, 32'hF000_0400, 32'h0, n);
    xfer(0, 1'b0, 4'hF, 32'hEFFF_FFFC, 32'h0, n);
    drain();
    chk_val("oor_rdata", last_rd[0], 32'hBADC_AB1E);
    chk_val("oor_errc2", 32'(errc[0]), 32'd2);
    xfer(0, 1'b1, 4'hF, 32'hF000_0800, 32'h1234_5678, n);
    drain();
    chk_val("oor_errc_model", 32'(errc[0]), 32'(errexp[0]));

    // GNT_WAIT=3: grant on 4th request cycle, also for a back-to-back request
    xfer(1, 1'b1, 4'hF, 32'hF000_0000, 32'h0BAD_F00D, n);
    chk_val("gnt_wait3_first", 32'(n), 32'd4);
    xfer(1, 1'b0, 4'hF, 32'hF000_0000, 32'h0, n);
    chk_val("gnt_wait3_b2b", 32'(n), 32'd4);
    drain();
    chk_val("wait3_read", last_rd[1], 32'h0BAD_F00D);

    // RVALID_LAT=4, MAX_OUTSTANDING=2: continuous reads
    xfer(2, 1'b1, 4'hF, 32'hF000_0020, 32'hCAFE_0020, n);
    drain();
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'hF000_0020;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_gen);
      g_seen[i] = gnt[2];
      r_seen[i] = rvalid[2];
      @(posedge clk_gen); #1;
    end
    req[2] = 1'b0;
    for (int i = 0; i < 12; i++)
      chk_val($sformatf("gnt_pattern_%0d", i), 32'(g_seen[i]), 32'((i % 4) < 2));
    chk_val("rv_first_at4", 32'(r_seen[4]), 32'd1);
    chk_val("rv_none_at3", 32'(r_seen[3]), 32'd0);
    drain();
    chk_val("lat4_read", last_rd[2], 32'hCAFE_0020);

    // reset while two reads are in flight and the first response is on the outputs
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'hF000_0020;
    repeat (4) @(posedge clk_gen);
    #1;
    chk_val("rv_before_rst", 32'(rvalid[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_val("rst_mid_rvalid", 32'(rvalid[2]), 32'd0);
    chk_val("rst_mid_gnt", 32'(gnt[2]), 32'd0);
    chk_val("rst_mid_errc", 32'(errc[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      sbq[k].delete();
      errexp[k] = 0;
    end
    req[2] = 1'b0;
    @(negedge clk_gen);
    rst_n = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_gen);
      if (rvalid[0] || rvalid[1] || rvalid[2]) rv_cnt++;
    end
    chk_val("no_stale_rvalid", 32'(rv_cnt), 32'd0);
    @(posedge clk_gen); #1;
    xfer(0, 1'b0, 4'hF, 32'hF000_0010, 32'h0, n);
    drain();
    chk_val("mem_persists", last_rd[0], 32'hDEAD_BEEF);
    xfer(0, 1'b0, 4'hF, 32'hF000_1000, 32'h0, n);
    drain();
    chk_val("errc_after_rst", 32'(errc[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
